fix_tx_arbiter: RTL and testbench
=================================

# fix_tx_arbiter

Message-granular round-robin arbiter that shares the single TOE transmit FIFO among NUM_HOST FIX session engines. Each engine emits framed byte streams (write/byte/end). The arbiter grants one engine at a time for a whole message, tags every byte with the owner's connection id, and forwards TOE back-pressure to that engine. It aborts a message whose host disconnects or stalls. It sits between the per-host session engines and the TOE transmit path in `end_to_end_system`.

## Interface
- NUM_HOST, 2, number of session engines (requesters); 2..4
- ID_W, 2, width of connection id; must satisfy 2**ID_W >= NUM_HOST
- TIMEOUT, 64, cycles a granted engine may go without presenting a byte (while not back-pressured) before abort; 2..255

- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous reset, active-low
- host_connected_i  in  NUM_HOST  per-host TOE connection status; unconnected hosts are never granted
- req_write_i  in  NUM_HOST  engine h presents a byte
- req_message_i  in  8*NUM_HOST  byte of engine h at [8h+7:8h]
- req_end_i  in  NUM_HOST  qualifies the presented byte as the last of the message
- req_full_o  out  NUM_HOST  back-pressure to engine h; engine holds write/byte/end while high
- fifo_full_i  in  1  TOE FIFO almost-full (guarantees ≥2 free entries when low)
- fifo_write_o  out  1  byte valid to TOE FIFO
- message_o  out  8  byte to TOE FIFO
- end_o  out  1  last byte of message (or abort marker)
- id_o  out  ID_W  owner host index, valid with fifo_write_o/end_o
- abort_o  out  1  message truncated; valid with end_o

## Operation
- States: IDLE, XFER, GAP.
- IDLE: all req_full_o=1. Eligible set is req_write_i & host_connected_i. If non-empty, the round-robin pick starting at pointer rr wins; store grant g; go to XFER. Otherwise stay in IDLE.
- XFER: req_full_o[g]=fifo_full_i and all other bits 1. A byte is accepted when req_write_i[g] & !fifo_full_i. Each accepted byte is registered to message_o/fifo_write_o/id_o=g; end_o=req_end_i[g]. When the accepted byte carries end: rr=g+1 (mod NUM_HOST), go to GAP.
- Stall counter: cleared on accept or when fifo_full_i=1, else incremented. Abort when it reaches TIMEOUT, or when host_connected_i[g] falls. On abort, the next cycle shows end_o=1, abort_o=1, fifo_write_o=0, id_o=g; rr=g+1; go to GAP. Any later bytes from that engine are treated as a new message.
- If disconnect and an accept happen in the same cycle, abort wins and the byte is dropped.
- GAP: one cycle, all req_full_o=1, then IDLE.
- rr is a log2 counter; wraps NUM_HOST-1 -> 0.

## Timing
- Reset (async, rst=0): state IDLE, rr=0, stall=0. Outputs: fifo_write_o=0, message_o=0x00, end_o=0, id_o=0, abort_o=0, req_full_o all 1. Deassertion takes effect on the next posedge.
- Reset mid-message drops the message silently (no end_o).
- Arbitration at edge N (IDLE). From N+1, req_full_o[g] follows fifo_full_i. A byte accepted at edge M appears on outputs during cycle M+1 (1-cycle latency).
- Outputs are registered pulses: fifo_write_o/end_o/abort_o are high exactly one cycle per event.
- Minimum per-message overhead: 2 idle cycles (arbitration + GAP). Back-to-back from same host is allowed only when no other eligible host exists.
- req_full_o is combinational from state, g and fifo_full_i.

## Structure
- fix_pkg: state enum (IDLE, XFER, GAP), ID_W default, byte type; shared with session engines.
- Sub-module fix_rr_arbiter: combinational pick from request vector + pointer, returning grant index and valid; reused by the RX dispatcher.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs at reset values, req_full_o=2'b11.
- Single host: host1 connected, sends 0x38,0x3D,0x46(end) -> fifo_write_o 3 cycles with those bytes, id_o=1, end_o on 0x46, abort_o=0, first byte 2 cycles after req_write_i rises.
- Contention: both hosts request at once, rr=0 -> host0's full message first, GAP, then host1's. Next simultaneous request grants host0 again only after host1 (alternation).
- Back-pressure: fifo_full_i=1 for 5 cycles mid-message -> req_full_o[g]=1, no fifo_write_o, no abort, message completes intact.
- Stall timeout: granted host stops writing after 2 bytes for TIMEOUT=64 cycles -> end_o=1, abort_o=1, fifo_write_o=0; other host granted after GAP.
- Disconnect: host_connected_i[g] drops mid-message -> abort marker next cycle. An unconnected host asserting req_write_i is never granted.

Source files
------------

// File: rtl/fix_pkg.sv
// Shared types for the FIX session / TOE transmit path.
package fix_pkg;

    localparam int unsigned ID_W_DEFAULT = 2;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_GAP
    } state_t;

endpackage

// File: rtl/fix_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module fix_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int unsigned    sum;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = 0;
        // Rotate so bit 0 is the pointer position, then take the lowest set bit.
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        for (int unsigned k = 0; k < N; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                sum   = 32'(ptr) + k;
                grant = IDX_W'((sum >= N) ? sum - N : sum);
            end
        end
    end

endmodule

// File: rtl/fix_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the TOE transmit FIFO among
// NUM_HOST session engines, with stall-timeout and disconnect abort.
module fix_tx_arbiter
    import fix_pkg::*;
#(
    parameter int unsigned NUM_HOST = 2,
    parameter int unsigned ID_W     = ID_W_DEFAULT,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HOST-1:0]   host_connected_i,
    input  logic [NUM_HOST-1:0]   req_write_i,
    input  logic [8*NUM_HOST-1:0] req_message_i,
    input  logic [NUM_HOST-1:0]   req_end_i,
    output logic [NUM_HOST-1:0]   req_full_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_write_o,
    output logic [7:0]            message_o,
    output logic                  end_o,
    output logic [ID_W-1:0]       id_o,
    output logic                  abort_o
);

    state_t              state;
    logic [ID_W-1:0]     g;
    logic [ID_W-1:0]     rr;
    logic [ID_W-1:0]     g_next;
    logic [7:0]          stall;

    logic [NUM_HOST-1:0] eligible;
    logic [ID_W-1:0]     pick;
    logic                pick_valid;

    logic                sel_write;
    logic                sel_end;
    logic                sel_conn;
    byte_t               sel_byte;
    logic                accept;
    logic                abort_now;

    assign eligible = req_write_i & host_connected_i;

    fix_rr_arbiter #(
        .N     (NUM_HOST),
        .IDX_W (ID_W)
    ) u_rr (
        .req   (eligible),
        .ptr   (rr),
        .grant (pick),
        .valid (pick_valid)
    );

    always_comb begin
        sel_write  = 1'b0;
        sel_end    = 1'b0;
        sel_conn   = 1'b0;
        sel_byte   = '0;
        req_full_o = '1;
        for (int unsigned h = 0; h < NUM_HOST; h++) begin
            if (g == ID_W'(h)) begin
                sel_write = req_write_i[h];
                sel_end   = req_end_i[h];
                sel_conn  = host_connected_i[h];
                sel_byte  = req_message_i[8*h +: 8];
                if (state == ST_XFER) begin
                    req_full_o[h] = fifo_full_i;
                end
            end
        end
    end

    assign accept    = (state == ST_XFER) && sel_write && !fifo_full_i;
    // Disconnect beats a same-cycle accept: the byte is dropped.
    assign abort_now = (state == ST_XFER) && (!sel_conn || stall == 8'(TIMEOUT));
    assign g_next    = (g == ID_W'(NUM_HOST - 1)) ? '0 : g + ID_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            g            <= '0;
            rr           <= '0;
            stall        <= '0;
            fifo_write_o <= 1'b0;
            message_o    <= '0;
            end_o        <= 1'b0;
            id_o         <= '0;
            abort_o      <= 1'b0;
        end else begin
            fifo_write_o <= 1'b0;
            end_o        <= 1'b0;
            abort_o      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    stall <= '0;
                    if (pick_valid) begin
                        g     <= pick;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (abort_now) begin
                        end_o   <= 1'b1;
                        abort_o <= 1'b1;
                        id_o    <= g;
                        rr      <= g_next;
                        stall   <= '0;
                        state   <= ST_GAP;
                    end else if (accept) begin
                        fifo_write_o <= 1'b1;
                        message_o    <= sel_byte;
                        end_o        <= sel_end;
                        id_o         <= g;
                        stall        <= '0;
                        if (sel_end) begin
                            rr    <= g_next;
                            state <= ST_GAP;
                        end
                    end else if (fifo_full_i) begin
                        stall <= '0;
                    end else begin
                        stall <= stall + 8'(1);
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fix_tx_arbiter.sv
// Directed self-checking bench for fix_tx_arbiter (NUM_HOST=2, TIMEOUT=64).
module tb_fix_tx_arbiter;

    localparam int unsigned NH = 2;
    localparam int unsigned IW = 2;
    localparam int unsigned TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [NH-1:0] conn;
    logic [NH-1:0] wr;
    logic [15:0]   msg;
    logic [NH-1:0] eop;
    logic [NH-1:0] req_full;
    logic          full;
    logic          fw;
    logic [7:0]    mo;
    logic          eo;
    logic [IW-1:0] id;
    logic          ab;

    int checks = 0;
    int errors = 0;

    fix_tx_arbiter #(.NUM_HOST(NH), .ID_W(IW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .host_connected_i (conn),
        .req_write_i      (wr),
        .req_message_i    (msg),
        .req_end_i        (eop),
        .req_full_o       (req_full),
        .fifo_full_i      (full),
        .fifo_write_o     (fw),
        .message_o        (mo),
        .end_o            (eo),
        .id_o             (id),
        .abort_o          (ab)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        conn = NH'($urandom);
        wr   = NH'($urandom);
        msg  = 16'($urandom);
        eop  = NH'($urandom);
        full = 1'($urandom);
        repeat (3) tick();
        checks++; if (fw !== 1'b0) begin errors++; $display("FAIL reset_fw got %b want 0", fw); end
        checks++; if (mo !== 8'h00) begin errors++; $display("FAIL reset_msg got %h want 00", mo); end
        checks++; if (eo !== 1'b0 || ab !== 1'b0) begin errors++; $display("FAIL reset_end_abort got %b%b want 00", eo, ab); end
        checks++; if (id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", id); end
        checks++; if (req_full !== 2'b11) begin errors++; $display("FAIL reset_full got %b want 11", req_full); end
        conn = '0; wr = '0; msg = '0; eop = '0; full = 1'b0;
        rst  = 1'b1;
        tick();
    endtask

    task automatic test_single_host();
        conn = 2'b10; wr = 2'b10; msg[15:8] = 8'h38; eop = 2'b00;
        tick();
        checks++; if (fw !== 1'b0 || req_full !== 2'b01) begin errors++; $display("FAIL single_grant fw=%b full=%b want 0/01", fw, req_full); end
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h38 || id !== 2'd1 || eo !== 1'b0) begin errors++; $display("FAIL single_b0 fw=%b msg=%h id=%0d end=%b want 1/38/1/0", fw, mo, id, eo); end
        msg[15:8] = 8'h3D;
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h3D || eo !== 1'b0) begin errors++; $display("FAIL single_b1 fw=%b msg=%h end=%b want 1/3d/0", fw, mo, eo); end
        msg[15:8] = 8'h46; eop = 2'b10;
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h46 || eo !== 1'b1 || ab !== 1'b0 || id !== 2'd1) begin errors++; $display("FAIL single_b2 fw=%b msg=%h end=%b abort=%b id=%0d want 1/46/1/0/1", fw, mo, eo, ab, id); end
        wr = '0; eop = '0;
        checks++; if (req_full !== 2'b11) begin errors++; $display("FAIL single_gap_full got %b want 11", req_full); end
        tick();
        checks++; if (fw !== 1'b0 || eo !== 1'b0) begin errors++; $display("FAIL single_pulse fw=%b end=%b want 0/0", fw, eo); end
    endtask

    task automatic test_contention();
        conn = 2'b11; wr = 2'b11; msg = {8'hB0, 8'hA0}; eop = 2'b10;
        tick();
        checks++; if (req_full !== 2'b10) begin errors++; $display("FAIL cont_grant0 full=%b want 10", req_full); end
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'hA0 || id !== 2'd0) begin errors++; $display("FAIL cont_a0 fw=%b msg=%h id=%0d want 1/a0/0", fw, mo, id); end
        msg[7:0] = 8'hA1; eop[0] = 1'b1;
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'hA1 || eo !== 1'b1 || id !== 2'd0) begin errors++; $display("FAIL cont_a1 fw=%b msg=%h end=%b id=%0d want 1/a1/1/0", fw, mo, eo, id); end
        wr[0] = 1'b0; eop[0] = 1'b0;
        tick();
        checks++; if (fw !== 1'b0 || req_full !== 2'b11) begin errors++; $display("FAIL cont_gap fw=%b full=%b want 0/11", fw, req_full); end
        tick();
        checks++; if (req_full !== 2'b01) begin errors++; $display("FAIL cont_grant1 full=%b want 01", req_full); end
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'hB0 || eo !== 1'b1 || id !== 2'd1) begin errors++; $display("FAIL cont_b0 fw=%b msg=%h end=%b id=%0d want 1/b0/1/1", fw, mo, eo, id); end
        wr = '0; eop = '0;
        tick();
        // host0 alone moves the pointer to host1
        wr = 2'b01; msg[7:0] = 8'hC0; eop = 2'b01;
        tick();
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'hC0 || id !== 2'd0) begin errors++; $display("FAIL cont_c0 fw=%b msg=%h id=%0d want 1/c0/0", fw, mo, id); end
        wr = '0; eop = '0;
        tick();
        wr = 2'b11; msg = {8'hE0, 8'hD0}; eop = 2'b11;
        tick();
        checks++; if (req_full !== 2'b01) begin errors++; $display("FAIL cont_alt_grant1 full=%b want 01", req_full); end
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'hE0 || id !== 2'd1) begin errors++; $display("FAIL cont_e0 fw=%b msg=%h id=%0d want 1/e0/1", fw, mo, id); end
        wr[1] = 1'b0; eop[1] = 1'b0;
        tick();
        tick();
        checks++; if (req_full !== 2'b10) begin errors++; $display("FAIL cont_alt_grant0 full=%b want 10", req_full); end
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'hD0 || id !== 2'd0) begin errors++; $display("FAIL cont_d0 fw=%b msg=%h id=%0d want 1/d0/0", fw, mo, id); end
        wr = '0; eop = '0;
        tick();
    endtask

    task automatic test_backpressure();
        int writes = 0;
        int aborts = 0;
        conn = 2'b11; wr = 2'b01; msg[7:0] = 8'h11; eop = 2'b00;
        tick();
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h11) begin errors++; $display("FAIL bp_b0 fw=%b msg=%h want 1/11", fw, mo); end
        msg[7:0] = 8'h22; full = 1'b1;
        #1;
        checks++; if (req_full !== 2'b11) begin errors++; $display("FAIL bp_full got %b want 11", req_full); end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (fw) writes++;
            if (ab || eo) aborts++;
        end
        checks++; if (writes != 0 || aborts != 0) begin errors++; $display("FAIL bp_hold writes=%0d ends=%0d want 0/0", writes, aborts); end
        full = 1'b0;
        #1;
        checks++; if (req_full !== 2'b10) begin errors++; $display("FAIL bp_release got %b want 10", req_full); end
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h22) begin errors++; $display("FAIL bp_b1 fw=%b msg=%h want 1/22", fw, mo); end
        msg[7:0] = 8'h33; eop = 2'b01;
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h33 || eo !== 1'b1 || ab !== 1'b0) begin errors++; $display("FAIL bp_b2 fw=%b msg=%h end=%b abort=%b want 1/33/1/0", fw, mo, eo, ab); end
        wr = '0; eop = '0;
        tick();
    endtask

    task automatic test_stall_timeout();
        int k = 0;
        int writes = 0;
        conn = 2'b11; wr = 2'b10; msg[15:8] = 8'h55; eop = 2'b00;
        tick();
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h55 || id !== 2'd1) begin errors++; $display("FAIL to_b0 fw=%b msg=%h id=%0d want 1/55/1", fw, mo, id); end
        msg[15:8] = 8'h66;
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h66) begin errors++; $display("FAIL to_b1 fw=%b msg=%h want 1/66", fw, mo); end
        wr = 2'b01; msg[7:0] = 8'h77; eop = 2'b01;
        do begin
            tick();
            k++;
            if (fw) writes++;
        end while (eo !== 1'b1 && k < 200);
        checks++; if (k < TO || k > TO + 2) begin errors++; $display("FAIL to_latency got %0d cycles want %0d..%0d", k, TO, TO + 2); end
        checks++; if (eo !== 1'b1 || ab !== 1'b1 || fw !== 1'b0 || id !== 2'd1 || writes != 0) begin errors++; $display("FAIL to_marker end=%b abort=%b fw=%b id=%0d writes=%0d want 1/1/0/1/0", eo, ab, fw, id, writes); end
        tick();
        checks++; if (req_full !== 2'b11 || ab !== 1'b0) begin errors++; $display("FAIL to_gap full=%b abort=%b want 11/0", req_full, ab); end
        tick();
        checks++; if (req_full !== 2'b10) begin errors++; $display("FAIL to_next_grant full=%b want 10", req_full); end
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h77 || id !== 2'd0 || eo !== 1'b1 || ab !== 1'b0) begin errors++; $display("FAIL to_next_msg fw=%b msg=%h id=%0d end=%b abort=%b want 1/77/0/1/0", fw, mo, id, eo, ab); end
        wr = '0; eop = '0;
        tick();
    endtask

    task automatic test_disconnect();
        int grants = 0;
        conn = 2'b11; wr = 2'b01; msg[7:0] = 8'h81; eop = 2'b00;
        tick();
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h81) begin errors++; $display("FAIL dc_b0 fw=%b msg=%h want 1/81", fw, mo); end
        msg[7:0] = 8'h82; conn = 2'b10;
        tick();
        checks++; if (eo !== 1'b1 || ab !== 1'b1 || fw !== 1'b0 || id !== 2'd0) begin errors++; $display("FAIL dc_marker end=%b abort=%b fw=%b id=%0d want 1/1/0/0", eo, ab, fw, id); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fw || req_full !== 2'b11) grants++;
        end
        checks++; if (grants != 0) begin errors++; $display("FAIL dc_unconnected_grant got %0d cycles want 0", grants); end
        wr = '0;
        tick();
    endtask

    task automatic test_reset_mid_message();
        conn = 2'b10; wr = 2'b10; msg[15:8] = 8'h99; eop = 2'b00;
        tick();
        tick();
        checks++; if (fw !== 1'b1 || mo !== 8'h99) begin errors++; $display("FAIL rm_b0 fw=%b msg=%h want 1/99", fw, mo); end
        #2 rst = 1'b0;
        #1;
        checks++; if (fw !== 1'b0 || mo !== 8'h00 || req_full !== 2'b11 || eo !== 1'b0) begin errors++; $display("FAIL rm_async fw=%b msg=%h full=%b end=%b want 0/00/11/0", fw, mo, req_full, eo); end
        wr = '0;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (fw !== 1'b0 || eo !== 1'b0 || ab !== 1'b0) begin errors++; $display("FAIL rm_after fw=%b end=%b abort=%b want 0/0/0", fw, eo, ab); end
    endtask

    initial begin
        test_reset();
        test_single_host();
        test_contention();
        test_backpressure();
        test_stall_timeout();
        test_disconnect();
        test_reset_mid_message();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
